// File: rtl/rob_retire_ctrl.sv
// ROB retirement controller: tracks completion state per entry, retires up to two
// in-order entries per cycle and sequences a flush/redirect on a mispredicted branch.
module rob_retire_ctrl #(
   parameter int ROB_IDX = 5,
   parameter int ROB_SZ  = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               alloc1_en,
   input  logic               alloc2_en,
   input  logic               cdb1_en,
   input  logic               cdb2_en,
   input  logic [ROB_IDX-1:0] cdb1_idx,
   input  logic [ROB_IDX-1:0] cdb2_idx,
   input  logic               cdb1_mispred,
   input  logic               cdb2_mispred,
   input  logic [63:0]        cdb1_target,
   input  logic [63:0]        cdb2_target,
   output logic               retire1,
   output logic               retire2,
   output logic               move_tail,
   output logic [ROB_IDX-1:0] tail_new,
   output logic               redirect_en,
   output logic [63:0]        redirect_pc,
   output logic               stall_dispatch,
   output logic [ROB_IDX-1:0] head,
   output logic [ROB_IDX-1:0] tail,
   output logic [ROB_IDX:0]   count
);

   localparam int CW = ROB_IDX + 1;
   localparam logic [ROB_IDX:0] STALL_TH = CW'(ROB_SZ - 2);

   typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

   state_t             r_state, w_state_nxt;
   logic [ROB_SZ-1:0]  r_done, r_mispred;
   logic [63:0]        r_target [ROB_SZ];
   logic [ROB_IDX-1:0] r_head, r_tail, r_tail_new;
   logic [ROB_IDX:0]   r_count;
   logic [63:0]        r_redirect_pc;

   logic               w_run, w_retire1, w_retire2, w_flush_start, w_stall;
   logic               w_alloc1, w_alloc2;
   logic [ROB_IDX-1:0] w_head1, w_tail1, w_head_nxt, w_tail_nxt;
   logic [ROB_IDX:0]   w_count_nxt;

   assign w_head1     = r_head + 1'b1;
   assign w_tail1     = r_tail + 1'b1;
   assign w_head_nxt  = r_head + ROB_IDX'(w_retire1) + ROB_IDX'(w_retire2);
   assign w_tail_nxt  = r_tail + ROB_IDX'(w_alloc1) + ROB_IDX'(w_alloc2);
   assign w_count_nxt = r_count + CW'(w_alloc1) + CW'(w_alloc2)
                        - CW'(w_retire1) - CW'(w_retire2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      move_tail     = 1'b0;
      redirect_en   = 1'b0;
      w_run         = (r_state == RUN);
      w_retire1     = w_run && (r_count != '0) && r_done[r_head];
      w_retire2     = w_retire1 && !r_mispred[r_head] && (r_count >= CW'(2))
                      && r_done[w_head1] && !r_mispred[w_head1];
      w_flush_start = w_retire1 && r_mispred[r_head];
      w_stall       = !w_run || (r_count > STALL_TH);
      w_alloc1      = alloc1_en && !w_stall;
      w_alloc2      = w_alloc1 && alloc2_en;
      case (r_state)
         RUN:     if (w_flush_start) w_state_nxt = FLUSH;
         FLUSH: begin
            w_state_nxt = RECOVER;
            move_tail   = 1'b1;
            redirect_en = 1'b1;
         end
         RECOVER: w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // Squash happens on the retiring edge so the FLUSH cycle already shows tail=head, count=0;
   // CDB/alloc activity in that same cycle belongs to the wrong path and is discarded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_done        <= '0;
         r_mispred     <= '0;
         r_tail_new    <= '0;
         r_redirect_pc <= '0;
      end else if (w_flush_start) begin
         r_head        <= w_head_nxt;
         r_tail        <= w_head_nxt;
         r_count       <= '0;
         r_done        <= '0;
         r_mispred     <= '0;
         r_tail_new    <= w_head_nxt;
         r_redirect_pc <= r_target[r_head];
      end else if (r_state == FLUSH) begin
         r_tail    <= r_head;
         r_count   <= '0;
         r_done    <= '0;
         r_mispred <= '0;
      end else if (w_run) begin
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         if (cdb2_en) begin
            r_done[cdb2_idx]    <= 1'b1;
            r_mispred[cdb2_idx] <= cdb2_mispred;
         end
         if (cdb1_en) begin
            r_done[cdb1_idx]    <= 1'b1;
            r_mispred[cdb1_idx] <= cdb1_mispred;
         end
         if (w_alloc1) begin
            r_done[r_tail]    <= 1'b0;
            r_mispred[r_tail] <= 1'b0;
         end
         if (w_alloc2) begin
            r_done[w_tail1]    <= 1'b0;
            r_mispred[w_tail1] <= 1'b0;
         end
      end
   end

   // cdb1 written last so it wins on an index collision
   always_ff @(posedge clk) begin
      if (w_run) begin
         if (cdb2_en) r_target[cdb2_idx] <= cdb2_target;
         if (cdb1_en) r_target[cdb1_idx] <= cdb1_target;
      end
   end

   assign retire1        = w_retire1;
   assign retire2        = w_retire2;
   assign stall_dispatch = w_stall;
   assign tail_new       = r_tail_new;
   assign redirect_pc    = r_redirect_pc;
   assign head           = r_head;
   assign tail           = r_tail;
   assign count          = r_count;

endmodule
